// File: rtl/alu_seq_nbit.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_nbit
// Purpose  : Parametrised registered ALU (AND/OR/ADD/SUB/XOR/SHL/SHR/MUL)
//            with C/Z/N/V flags and valid/ready handshakes on both sides.
//            Multiply is an iterative shift-add, one multiplier bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_nbit #(
  parameter int WIDTH  = 16,
  parameter int MUL_EN = 1,
  parameter int SHW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  localparam logic [2:0] c_op_and = 3'b000;
  localparam logic [2:0] c_op_or  = 3'b001;
  localparam logic [2:0] c_op_add = 3'b010;
  localparam logic [2:0] c_op_sub = 3'b011;
  localparam logic [2:0] c_op_xor = 3'b100;
  localparam logic [2:0] c_op_shl = 3'b101;
  localparam logic [2:0] c_op_shr = 3'b110;
  localparam logic [2:0] c_op_mul = 3'b111;
  localparam bit         c_mul_en = (MUL_EN != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_result;
  logic               r_c, r_z, r_n, r_v;
  logic               r_in_ready, r_out_valid;

  logic               w_accept;
  logic [SHW-1:0]     w_shamt;
  logic [WIDTH:0]     w_add, w_sub, w_shl, w_shr;
  logic [WIDTH-1:0]   w_res;
  logic               w_c, w_v;
  logic [2*WIDTH-1:0] w_mul_acc_next;
  logic               w_mul_last;

  assign w_accept = in_valid & r_in_ready;
  assign w_shamt  = b[SHW-1:0];

  // Extra bit on each side of the shifters captures the last bit shifted out;
  // with a zero shift amount that bit is the padding zero, giving C=0.
  assign w_add = {1'b0, a} + {1'b0, b};
  assign w_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_shl = {1'b0, a} << w_shamt;
  assign w_shr = {a, 1'b0} >> w_shamt;

  // Single-cycle result, carry and overflow selected by opcode
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (op)
      c_op_and: w_res = a & b;
      c_op_or:  w_res = a | b;
      c_op_xor: w_res = a ^ b;
      c_op_add: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (a[WIDTH-1] ~^ b[WIDTH-1]) & (w_add[WIDTH-1] ^ a[WIDTH-1]);
      end
      c_op_sub: begin
        w_res = w_sub[WIDTH-1:0];
        w_c   = w_sub[WIDTH];
        w_v   = (a[WIDTH-1] ~^ ~b[WIDTH-1]) & (w_sub[WIDTH-1] ^ a[WIDTH-1]);
      end
      c_op_shl: begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      c_op_shr: begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      default: begin
        // Multiply without the multiplier yields zero in one cycle
        w_res = '0;
      end
    endcase
  end

  generate
    if (c_mul_en) begin : g_mul
      localparam logic [SHW-1:0] c_last = SHW'(WIDTH - 1);
      logic [2*WIDTH-1:0] r_acc;
      logic [2*WIDTH-1:0] r_mcand;
      logic [WIDTH-1:0]   r_mplier;
      logic [SHW-1:0]     r_count;
      logic               w_start;
      logic               w_step;

      assign w_start        = w_accept && (r_state == S_IDLE) && (op == c_op_mul);
      assign w_step         = (r_state == S_MUL);
      assign w_mul_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
      assign w_mul_last     = (r_count == c_last);

      // Shift-add: multiplicand walks left, multiplier walks right, so bit
      // "count" of the original multiplier is always at r_mplier[0]
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_acc    <= '0;
          r_mcand  <= '0;
          r_mplier <= '0;
          r_count  <= '0;
        end else if (w_start) begin
          r_acc    <= '0;
          r_mcand  <= {{WIDTH{1'b0}}, a};
          r_mplier <= b;
          r_count  <= '0;
        end else if (w_step) begin
          r_acc    <= w_mul_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + SHW'(1);
        end
      end
    end else begin : g_no_mul
      assign w_mul_acc_next = '0;
      assign w_mul_last     = 1'b0;
    end
  endgenerate

  // Control FSM; handshake outputs and result/flags are all registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_result    <= '0;
      r_c         <= 1'b0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_v         <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_in_ready <= 1'b0;
            if (c_mul_en && (op == c_op_mul)) begin
              r_state <= S_MUL;
            end else begin
              r_state     <= S_DONE;
              r_result    <= w_res;
              r_c         <= w_c;
              r_z         <= (w_res == '0);
              r_n         <= w_res[WIDTH-1];
              r_v         <= w_v;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (w_mul_last) begin
            r_state     <= S_DONE;
            r_result    <= w_mul_acc_next[WIDTH-1:0];
            r_c         <= |w_mul_acc_next[2*WIDTH-1:WIDTH];
            r_z         <= (w_mul_acc_next[WIDTH-1:0] == '0);
            r_n         <= w_mul_acc_next[WIDTH-1];
            r_v         <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flag_c    = r_c;
  assign flag_z    = r_z;
  assign flag_n    = r_n;
  assign flag_v    = r_v;

endmodule
`default_nettype wire

// File: doc/alu_seq_nbit.md
Name: alu_seq_nbit

Overview:
Parametrised, registered successor to the 16-bit ripple AND/OR/ADD/SUB ALU. Width is generic, and the operation set adds XOR, logical shifts and an iterative shift-add multiply. Results and status flags (C/Z/N/V) are registered and carried on a valid/ready handshake at input and output. The block sits between an operand source (register file or sequencer) and a result sink that may apply backpressure.

Parameters:
WIDTH, 16, operand/result width; power of two, >= 4
MUL_EN, 1, 1 = multiply implemented; 0 = op 111 returns zero
SHW, $clog2(WIDTH), derived shift-amount width; not overridden

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operands/op presented
in_ready  out  1  block can accept
op  in  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 SHL, 110 SHR, 111 MUL
a  in  WIDTH  operand A
b  in  WIDTH  operand B (shift amount = b[SHW-1:0])
out_valid  out  1  result/flags valid
out_ready  in  1  sink accepts result
result  out  WIDTH  registered result
flag_c  out  1  carry / no-borrow / shifted-out bit / multiply truncation
flag_z  out  1  result == 0
flag_n  out  1  result[WIDTH-1]
flag_v  out  1  signed overflow (ADD/SUB only)

Behaviour:
- Reset (async, any state): state=IDLE; result=0; all flags 0; out_valid=0; multiply counter/accumulator 0. in_ready=1 from the first edge after rst deasserts. Reset mid-multiply aborts the operation and discards it.
- States: IDLE, MUL, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- Accept = in_valid && in_ready at a rising edge; a, b and op are captured on that edge. Inputs are ignored outside IDLE.
- Single-cycle ops (000–110, and 111 with MUL_EN=0): on the accepting edge, result/flags are loaded and state goes IDLE->DONE. out_valid is high in the cycle after acceptance (latency 1).
- MUL (MUL_EN=1): on the accepting edge, state goes IDLE->MUL. The accumulator (2*WIDTH bits) is cleared, the multiplicand is loaded and count=0. Each subsequent edge:
  - if multiplier bit[count] is set, add multiplicand<<count to the accumulator;
  - then count+1.
  On the edge that processes bit WIDTH-1, state goes MUL->DONE and result = acc[WIDTH-1:0]. out_valid therefore rises WIDTH cycles after acceptance. Operands are unsigned.
- DONE: result and flags are held stable while out_ready=0. On an edge with out_ready=1, state goes DONE->IDLE. There is no same-cycle accept, so peak throughput is one op per two cycles for single-cycle ops.
- Arithmetic:
  - ADD: {c,sum} = a + b.
  - SUB: {c,diff} = a + ~b + 1, so c=1 means no borrow (unified adder convention).
  - V (ADD/SUB) = (a_msb ~^ b'_msb) & (res_msb ^ a_msb), where b' is b for ADD and ~b for SUB. V=0 for all other ops.
- Shifts are logical with amount s=b[SHW-1:0] (effectively b mod WIDTH):
  - SHL: C = a[WIDTH-s] if s>0, else 0.
  - SHR: C = a[s-1] if s>0, else 0.
  - s=0 returns a unchanged.
- MUL: C = |acc[2W-1:W] (high half nonzero, i.e. truncation).
- AND/OR/XOR, and MUL with MUL_EN=0: C=0.
- Z and N are always derived from the registered result.
- With MUL_EN=0, op 111 returns result=0, Z=1, C=N=V=0, latency 1; no multiply logic is instantiated.

Test Plan:
- ADD a=0xFFFF, b=0x0001 (WIDTH=16) -> out_valid high 1 cycle after accept; result=0x0000, C=1, Z=1, N=0, V=0.
- SUB a=0x8000, b=0x0001 -> result=0x7FFF, C=1, V=1, N=0. SUB a=0x0001, b=0x0002 -> result=0xFFFF, C=0, N=1, V=0.
- MUL a=0x0123, b=0x0010 -> out_valid rises exactly 16 cycles after accept; result=0x1230, C=0. MUL 0xFFFF*0x0002 -> 0xFFFE, C=1. in_ready=0 throughout.
- SHL a=0x8001, b=1 -> 0x0002, C=1. SHR a=0x8001, b=0x0010 (s=0) -> 0x8001, C=0, N=1. XOR 0xAAAA^0xAAAA -> 0x0000, Z=1.
- Backpressure: hold out_ready=0 for 5 cycles after an OR result with in_valid=1 and changing a/b -> result/flags stable, in_ready=0, no new op accepted; out_ready=1 -> IDLE next edge, then the next op is accepted.
- Assert rst during MUL cycle 5 -> all outputs 0 immediately (async); after release, in_ready=1 and ADD 0x0002+0x0003 -> 0x0005, C=0. Re-run the MUL vectors with MUL_EN=0 -> result 0, Z=1, latency 1.
